med_strip_rasterizer: RTL and testbench



---
 rtl/med_pkg.sv | 40 ++++
 rtl/med_strip_bank.sv | 33 +++
 rtl/med_strip_rasterizer.sv | 132 +++++++++++++
 tb/tb_med_strip_rasterizer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/med_pkg.sv
// Shared constants and helpers for the median strip rasterizer.
// PIX_W/TILE_W/STRIP_ROWS/IMG_W/IMG_H describe pixel, tile and frame geometry;
// TPR and NSTRIP are the derived tiles-per-row and strips-per-frame counts.
package med_pkg;

  localparam int unsigned PIX_W      = 8;
  localparam int unsigned TILE_W     = 12;
  localparam int unsigned STRIP_ROWS = 3;
  localparam int unsigned IMG_W      = 636;
  localparam int unsigned IMG_H      = 480;

  localparam int unsigned TPR    = IMG_W / TILE_W;
  localparam int unsigned NSTRIP = IMG_H / STRIP_ROWS;

  localparam int unsigned BLOCKS      = TILE_W / 3;
  localparam int unsigned BLK_BITS    = 9 * PIX_W;
  localparam int unsigned ROW_BITS    = TILE_W * PIX_W;
  localparam int unsigned TILE_IDX_W  = $clog2(TPR);
  localparam int unsigned STRIP_IDX_W = $clog2(NSTRIP);
  localparam int unsigned ROW_IDX_W   = $clog2(STRIP_ROWS);

  typedef logic [PIX_W-1:0]    pix_t;
  typedef logic [ROW_BITS-1:0] row_t;

  // Gather tile row r from the four 3x3 blocks; blks holds block 0 in its top bits.
  // Inside a block, pixel (r,k) sits at byte 8-(3r+k); in the row, leftmost is the MSB.
  function automatic row_t tile_row(input logic [BLOCKS*BLK_BITS-1:0] blks, input int r);
    row_t row;
    pix_t p;
    row = '0;
    for (int b = 0; b < int'(BLOCKS); b++) begin
      for (int k = 0; k < 3; k++) begin
        p = blks[BLOCKS*BLK_BITS-1 - b*BLK_BITS - (r*3+k)*PIX_W -: PIX_W];
        row[ROW_BITS-1 - (b*3+k)*PIX_W -: PIX_W] = p;
      end
    end
    return row;
  endfunction

endpackage

// File: rtl/med_strip_bank.sv
// One strip bank: STRIP_ROWS x TPR entries of one 12-pixel tile row each.
// clk_i      : write clock
// we_i       : write all three rows of tile wr_tile_i in one cycle
// wr_rows_i  : rows to write, element r = tile row r
// rd_row_i / rd_tile_i / rd_data_o : combinational read of one entry
// Contents are deliberately not reset.
module med_strip_bank
  import med_pkg::*;
(
  input  logic                               clk_i,
  input  logic                               we_i,
  input  logic [TILE_IDX_W-1:0]              wr_tile_i,
  input  logic [STRIP_ROWS-1:0][ROW_BITS-1:0] wr_rows_i,
  input  logic [ROW_IDX_W-1:0]               rd_row_i,
  input  logic [TILE_IDX_W-1:0]              rd_tile_i,
  output row_t                               rd_data_o
);

  row_t mem_q [STRIP_ROWS][TPR];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int r = 0; r < int'(STRIP_ROWS); r++) begin
        mem_q[r][wr_tile_i] <= wr_rows_i[r];
      end
    end
  end

  always_comb begin
    rd_data_o = mem_q[rd_row_i][rd_tile_i];
  end

endmodule

// File: rtl/med_strip_rasterizer.sv
// Collects 3-row strips of 3x12 tiles into a double-buffered store and replays
// them in raster order, one 12-pixel row segment per beat.
// clk, rst            : clock and asynchronous active-high reset
// in_valid/in_ready   : tile handshake, tile on block_in_0..3 (left to right)
// out_valid/out_ready : beat handshake, pixels on out_pix (leftmost in MSBs)
// out_row/out_col     : image position of the beat; out_sof/eol/eof framing flags
module med_strip_rasterizer
  import med_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BLK_BITS-1:0] block_in_0,
  input  logic [BLK_BITS-1:0] block_in_1,
  input  logic [BLK_BITS-1:0] block_in_2,
  input  logic [BLK_BITS-1:0] block_in_3,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ROW_BITS-1:0] out_pix,
  output logic [8:0]          out_row,
  output logic [9:0]          out_col,
  output logic                out_sof,
  output logic                out_eol,
  output logic                out_eof
);

  localparam logic [TILE_IDX_W-1:0]  LastTile  = TILE_IDX_W'(TPR - 1);
  localparam logic [ROW_IDX_W-1:0]   LastRRow  = ROW_IDX_W'(STRIP_ROWS - 1);
  localparam logic [STRIP_IDX_W-1:0] LastStrip = STRIP_IDX_W'(NSTRIP - 1);
  localparam logic [8:0]             LastRow   = 9'(IMG_H - 1);

  logic                   wr_bank_q, wr_bank_d;
  logic [TILE_IDX_W-1:0]  wr_tile_q, wr_tile_d;
  logic [1:0]             full_q, full_d;
  logic                   rd_bank_q, rd_bank_d;
  logic [ROW_IDX_W-1:0]   rd_row_q, rd_row_d;
  logic [TILE_IDX_W-1:0]  rd_tile_q, rd_tile_d;
  logic [STRIP_IDX_W-1:0] strip_q, strip_d;

  logic accept, consume;
  logic [STRIP_ROWS-1:0][ROW_BITS-1:0] wr_rows;
  row_t rd_data [2];

  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  always_comb begin
    for (int r = 0; r < int'(STRIP_ROWS); r++) begin
      wr_rows[r] = tile_row({block_in_0, block_in_1, block_in_2, block_in_3}, r);
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    med_strip_bank u_bank (
      .clk_i     (clk),
      .we_i      (accept && (wr_bank_q == 1'(g))),
      .wr_tile_i (wr_tile_q),
      .wr_rows_i (wr_rows),
      .rd_row_i  (rd_row_q),
      .rd_tile_i (rd_tile_q),
      .rd_data_o (rd_data[g])
    );
  end

  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_tile_d = wr_tile_q;
    full_d    = full_q;
    rd_bank_d = rd_bank_q;
    rd_row_d  = rd_row_q;
    rd_tile_d = rd_tile_q;
    strip_d   = strip_q;

    if (accept) begin
      if (wr_tile_q == LastTile) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_tile_d         = '0;
      end else begin
        wr_tile_d = wr_tile_q + 1'b1;
      end
    end

    // Writer and reader never hold the same full bank, so set/clear cannot collide.
    if (consume) begin
      if (rd_tile_q == LastTile) begin
        rd_tile_d = '0;
        if (rd_row_q == LastRRow) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
          rd_row_d          = '0;
          strip_d           = (strip_q == LastStrip) ? '0 : strip_q + 1'b1;
        end else begin
          rd_row_d = rd_row_q + 1'b1;
        end
      end else begin
        rd_tile_d = rd_tile_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q <= 1'b0;
      wr_tile_q <= '0;
      full_q    <= '0;
      rd_bank_q <= 1'b0;
      rd_row_q  <= '0;
      rd_tile_q <= '0;
      strip_q   <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      wr_tile_q <= wr_tile_d;
      full_q    <= full_d;
      rd_bank_q <= rd_bank_d;
      rd_row_q  <= rd_row_d;
      rd_tile_q <= rd_tile_d;
      strip_q   <= strip_d;
    end
  end

  assign out_pix = rd_data[rd_bank_q];
  assign out_row = ({1'b0, strip_q} * 9'd3) + {{(9-ROW_IDX_W){1'b0}}, rd_row_q};
  assign out_col = {{(10-TILE_IDX_W){1'b0}}, rd_tile_q} * 10'(TILE_W);
  assign out_sof = (out_row == 9'd0) && (rd_tile_q == '0);
  assign out_eol = (rd_tile_q == LastTile);
  assign out_eof = out_eol && (out_row == LastRow);

endmodule

// File: tb/tb_med_strip_rasterizer.sv
module tb_med_strip_rasterizer;
  import med_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [71:0] b0 = '0, b1 = '0, b2 = '0, b3 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [95:0] out_pix;
  logic [8:0]  out_row;
  logic [9:0]  out_col;
  logic        out_sof, out_eol, out_eof;

  med_strip_rasterizer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .block_in_0 (b0),
    .block_in_1 (b1),
    .block_in_2 (b2),
    .block_in_3 (b3),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pix    (out_pix),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .out_eof    (out_eof)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] pix;
    logic [8:0]  row;
    logic [9:0]  col;
    logic        sof, eol, eof;
  } beat_t;

  beat_t sb[$];
  int n_cmp = 0, n_bad = 0;
  int beats_seen = 0, sof_seen = 0, eol_seen = 0, eof_seen = 0;
  bit mon_en = 1'b0;
  int ready_mode = 2;
  int rdy_phase = 0;

  // Image content model: mode 0 ramp, mode 1 single marker, mode 2 hash.
  function automatic logic [7:0] pix_f(int mode, int s, int r, int c);
    case (mode)
      0:       return 8'(7 * (s * 3 + r) + c);
      1:       return (r == 0 && c % 12 == 3) ? 8'hA5 : 8'h00;
      default: return 8'(s * 37 + r * 101 + c * 13 + 11);
    endcase
  endfunction

  task automatic drive_tile(int mode, int s, int t);
    logic [71:0] blk [4];
    for (int b = 0; b < 4; b++) begin
      blk[b] = '0;
      for (int r = 0; r < 3; r++)
        for (int k = 0; k < 3; k++)
          blk[b][71 - 8 * (r * 3 + k) -: 8] = pix_f(mode, s, r, t * 12 + b * 3 + k);
    end
    b0 = blk[0]; b1 = blk[1]; b2 = blk[2]; b3 = blk[3];
  endtask

  task automatic push_strip(int mode, int s);
    beat_t e;
    for (int r = 0; r < 3; r++) begin
      for (int t = 0; t < 53; t++) begin
        for (int i = 0; i < 12; i++) e.pix[95 - 8 * i -: 8] = pix_f(mode, s, r, t * 12 + i);
        e.row = 9'((s % 160) * 3 + r);
        e.col = 10'(t * 12);
        e.sof = (e.row == 9'd0) && (e.col == 10'd0);
        e.eol = (t == 52);
        e.eof = e.eol && (e.row == 9'd479);
        sb.push_back(e);
      end
    end
  endtask

  task automatic send_strips(int first, int n, int mode);
    int wcnt;
    for (int s = first; s < first + n; s++) begin
      for (int t = 0; t < 53; t++) begin
        @(negedge clk);
        drive_tile(mode, s, t);
        in_valid = 1'b1;
        wcnt = 0;
        while (!in_ready) begin
          @(negedge clk);
          wcnt++;
          if (wcnt > 2000) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout strip=%0d tile=%0d in_ready=%b want 1", s, t, in_ready);
            in_valid = 1'b0;
            return;
          end
        end
        if (t == 52) push_strip(mode, s);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int c = 0;
    while (sb.size() != 0 && c < 20000) begin
      @(negedge clk);
      c++;
    end
    #3;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout left=%0d want 0", sb.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en = 1'b0;
    rst = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    beats_seen = 0; sof_seen = 0; eol_seen = 0; eof_seen = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  always @(negedge clk) begin
    rdy_phase++;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (rdy_phase % 4 == 0) || (rdy_phase % 4 == 3);
      default: out_ready = 1'b0;
    endcase
  end

  // Scoreboard: every presented beat (stalled or consumed) must match the queue head.
  always @(negedge clk) begin
    #2;
    if (mon_en && out_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_beat row=%0d col=%0d want no beat", out_row, out_col);
      end else begin
        if (out_pix !== sb[0].pix || out_row !== sb[0].row || out_col !== sb[0].col ||
            out_sof !== sb[0].sof || out_eol !== sb[0].eol || out_eof !== sb[0].eof) begin
          n_bad++;
          $display("FAIL beat got pix=%h row=%0d col=%0d sef=%b%b%b want pix=%h row=%0d col=%0d sef=%b%b%b",
                   out_pix, out_row, out_col, out_sof, out_eol, out_eof,
                   sb[0].pix, sb[0].row, sb[0].col, sb[0].sof, sb[0].eol, sb[0].eof);
        end
        if (out_ready) begin
          void'(sb.pop_front());
          beats_seen++;
          sof_seen += int'(out_sof);
          eol_seen += int'(out_eol);
          eof_seen += int'(out_eof);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_row !== 9'd0 || out_col !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_active rdy=%b vld=%b row=%0d col=%0d want 1 0 0 0",
               in_ready, out_valid, out_row, out_col);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_single_strip();
    do_reset();
    ready_mode = 0;
    send_strips(0, 1, 0);
    wait_drain();
    n_cmp++;
    if (beats_seen != 159 || sof_seen != 1 || eol_seen != 3 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_strip beats=%0d sof=%0d eol=%0d vld=%b want 159 1 3 0",
               beats_seen, sof_seen, eol_seen, out_valid);
    end
  endtask

  task automatic test_byte_map();
    do_reset();
    ready_mode = 0;
    send_strips(0, 1, 1);
    wait_drain();
    n_cmp++;
    if (beats_seen != 159) begin
      n_bad++;
      $display("FAIL byte_map_count beats=%0d want 159", beats_seen);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready_mode = 1;
    send_strips(0, 2, 2);
    wait_drain();
    n_cmp++;
    if (beats_seen != 318) begin
      n_bad++;
      $display("FAIL backpressure_count beats=%0d want 318", beats_seen);
    end
    ready_mode = 0;
  endtask

  task automatic test_both_full();
    int c = 0;
    do_reset();
    ready_mode = 2;
    send_strips(0, 2, 2);
    drive_tile(2, 2, 0);
    in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL both_full_ready rdy=%b want 0", in_ready);
      end
    end
    ready_mode = 0;
    while (beats_seen < 159 && c < 2000) begin
      @(negedge clk);
      #3;
      c++;
    end
    n_cmp++;
    if (beats_seen != 159 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL both_full_last_beat beats=%0d rdy=%b want 159 0", beats_seen, in_ready);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL both_full_reassert rdy=%b want 1", in_ready);
    end
    in_valid = 1'b0;
    send_strips(2, 1, 2);
    wait_drain();
    n_cmp++;
    if (beats_seen != 477) begin
      n_bad++;
      $display("FAIL both_full_count beats=%0d want 477", beats_seen);
    end
  endtask

  task automatic test_frame_wrap();
    do_reset();
    ready_mode = 0;
    send_strips(0, 161, 2);
    wait_drain();
    n_cmp++;
    if (beats_seen != 161 * 159 || eof_seen != 1 || sof_seen != 2) begin
      n_bad++;
      $display("FAIL frame_wrap beats=%0d eof=%0d sof=%0d want %0d 1 2",
               beats_seen, eof_seen, sof_seen, 161 * 159);
    end
  endtask

  task automatic test_reset_mid_drain();
    int c = 0;
    do_reset();
    ready_mode = 0;
    send_strips(0, 3, 2);
    while (beats_seen < 318 + 40 && c < 2000) begin
      @(negedge clk);
      #3;
      c++;
    end
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (beats_seen != 358 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_drain beats=%0d vld=%b rdy=%b want 358 0 1",
               beats_seen, out_valid, in_ready);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    beats_seen = 0; sof_seen = 0; eol_seen = 0; eof_seen = 0;
    mon_en = 1'b1;
    send_strips(0, 1, 0);
    wait_drain();
    n_cmp++;
    if (beats_seen != 159 || sof_seen != 1) begin
      n_bad++;
      $display("FAIL reset_restart beats=%0d sof=%0d want 159 1", beats_seen, sof_seen);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_strip();
    test_byte_map();
    test_backpressure();
    test_both_full();
    test_frame_wrap();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
